muldiv_ctrl: RTL and testbench

Iterative RV32M multiply/divide unit that sequences one shared add/subtract-and-shift datapath over XLEN cycles. It sits beside the single-cycle ALU in the execute stage. The decoder routes funct7=0000001 R-type instructions here instead of to the ALU. The block holds the pipeline stalled through `busy` until a one-cycle `done` pulse delivers the result.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_if.sv | 17 +
 rtl/muldiv_step.sv | 30 +++
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types, op encodings and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_mode_e;

   function automatic logic is_div(input md_op_e op);
      return op[2];
   endfunction

   function automatic logic a_signed(input md_op_e op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic b_signed(input md_op_e op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if;
   import muldiv_pkg::*;

   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, op, a, b, flush, input busy, done, result);
   modport slave  (input start, op, a, b, flush, output busy, done, result);

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module muldiv_step
   import muldiv_pkg::*;
(
   input  step_mode_e        mode,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   input  logic              bit_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic            ge;
   logic [XLEN-1:0] rem_nx;

   // bit_i is the multiplier LSB when multiplying and the next dividend bit when dividing
   always_comb begin
      sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (opnd_i & {XLEN{bit_i}})};
      rem_sh = {acc_i[2*XLEN-1:XLEN], bit_i};
      ge     = (rem_sh >= {1'b0, opnd_i});
      rem_nx = ge ? (rem_sh[XLEN-1:0] - opnd_i) : rem_sh[XLEN-1:0];
      if (mode == STEP_MUL) begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end else begin
         acc_o = {rem_nx, acc_i[XLEN-2:0], ge};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide controller; MULDIV_EARLY_OUT_EN skips CALC for zero operands.
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | XLEN iterations of the shared datapath
// S_FIX  | sign correction, special cases, result register load
// S_DONE | done pulse; start here issues back-to-back
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   muldiv_if.slave bus
);

   localparam int              CNT_W   = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);

   state_e              state_q,  state_d;
   md_op_e              op_q,     op_d;
   logic                a_neg_q,  a_neg_d;
   logic                b_neg_q,  b_neg_d;
   logic                b_zero_q, b_zero_d;
   logic [XLEN-1:0]     a_raw_q,  a_raw_d;
   logic [XLEN-1:0]     opnd_q,   opnd_d;
   logic [XLEN-1:0]     sh_q,     sh_d;
   logic [2*XLEN-1:0]   acc_q,    acc_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic [XLEN-1:0]     result_q, result_d;

   md_op_e              op_in;
   logic                a_neg_in, b_neg_in;
   logic [XLEN-1:0]     a_abs, b_abs;
   step_mode_e          mode_w;
   logic                bit_w;
   logic [2*XLEN-1:0]   step_w;
   logic [2*XLEN-1:0]   prod_w;
   logic [XLEN-1:0]     quot_w, rem_w, fix_w;

   assign op_in    = md_op_e'(bus.op);
   assign a_neg_in = a_signed(op_in) & bus.a[XLEN-1];
   assign b_neg_in = b_signed(op_in) & bus.b[XLEN-1];
   assign a_abs    = a_neg_in ? -bus.a : bus.a;
   assign b_abs    = b_neg_in ? -bus.b : bus.b;

`ifdef MULDIV_EARLY_OUT_EN
   logic skip_w;
   assign skip_w = is_div(op_in) ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`endif

   // sh_q streams multiplier bits out of its LSB, or dividend bits out of its MSB
   assign mode_w = is_div(op_q) ? STEP_DIV : STEP_MUL;
   assign bit_w  = is_div(op_q) ? sh_q[XLEN-1] : sh_q[0];

   muldiv_step u_step (
      .mode   (mode_w),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .bit_i  (bit_w),
      .acc_o  (step_w)
   );

   always_comb begin
      prod_w = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
      quot_w = acc_q[XLEN-1:0];
      rem_w  = acc_q[2*XLEN-1:XLEN];
      case (op_q)
         MD_MUL:                       fix_w = prod_w[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_w = prod_w[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_w = b_zero_q ? '1 : ((a_neg_q ^ b_neg_q) ? -quot_w : quot_w);
         default:                      fix_w = b_zero_q ? a_raw_q : (a_neg_q ? -rem_w : rem_w);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      b_zero_d = b_zero_q;
      a_raw_d  = a_raw_q;
      opnd_d   = opnd_q;
      sh_d     = sh_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (bus.flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  op_d     = op_in;
                  a_neg_d  = a_neg_in;
                  b_neg_d  = b_neg_in;
                  b_zero_d = (bus.b == '0);
                  a_raw_d  = bus.a;
                  opnd_d   = is_div(op_in) ? b_abs : a_abs;
                  sh_d     = is_div(op_in) ? a_abs : b_abs;
                  acc_d    = '0;
                  cnt_d    = '0;
`ifdef MULDIV_EARLY_OUT_EN
                  state_d  = skip_w ? S_FIX : S_CALC;
`else
                  state_d  = S_CALC;
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CALC: begin
               acc_d = step_w;
               sh_d  = is_div(op_q) ? {sh_q[XLEN-2:0], 1'b0} : {1'b0, sh_q[XLEN-1:1]};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_MAX) state_d = S_FIX;
            end
            S_FIX: begin
               result_d = fix_w;
               state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= MD_MUL;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         a_raw_q  <= '0;
         opnd_q   <= '0;
         sh_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         b_zero_q <= b_zero_d;
         a_raw_q  <= a_raw_d;
         opnd_q   <= opnd_d;
         sh_q     <= sh_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; zero-operand latencies follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int ZCYC  = 2;
   localparam int ZBUSY = 1;
`else
   localparam int ZCYC  = 34;
   localparam int ZBUSY = 33;
`endif

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   muldiv_if bus ();

   muldiv_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // cyc counts edges from the start-sampling edge through the edge that raises done
   task automatic wait_done(input int poke, output int cyc, output int bcyc);
      cyc  = 1;
      bcyc = bus.busy ? 1 : 0;
      while (cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.busy) bcyc++;
         if (cyc == poke) begin
            bus.op    = MD_DIVU;
            bus.a     = 32'd9;
            bus.b     = 32'd3;
            bus.start = 1'b1;
         end else if (cyc == poke + 1) begin
            bus.start = 1'b0;
         end
         if (bus.done) break;
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_cyc, input int exp_busy);
      int cyc, bcyc;
      issue(op, a, b);
      wait_done(-10, cyc, bcyc);
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_res"}, bus.result, exp);
      chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_busy"}, 32'(bcyc), 32'(exp_busy));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_hold"}, bus.result, exp);
   endtask

   initial begin
      int cyc, bcyc, ndone;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 3'b000;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #10;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 33);
      do_op("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 33);
      do_op("mul_neg", MD_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 34, 33);
      do_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 33);
      do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33);
      do_op("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33);
      do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 33);
      do_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 33);
      do_op("divu_z", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, ZCYC, ZBUSY);
      do_op("remu_z", MD_REMU, 32'd5, 32'd0, 32'd5, ZCYC, ZBUSY);
      do_op("div_z", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, ZCYC, ZBUSY);
      do_op("rem_z", MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, ZCYC, ZBUSY);
      do_op("mul_z", MD_MUL, 32'd0, 32'h0001_2345, 32'd0, ZCYC, ZBUSY);

      // flush sampled on the tenth edge after start
      issue(MD_MUL, 32'd3, 32'd5);
      repeat (8) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush_busy", 32'(bus.busy), 32'd0);
      chk("flush_done", 32'(bus.done), 32'd0);
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("flush_nodone", 32'(ndone), 32'd0);
      chk("flush_keep", bus.result, 32'd0);
      do_op("post_flush", MD_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 34, 33);

      // asynchronous reset in the middle of a divide
      issue(MD_DIV, 32'd100, 32'd3);
      repeat (18) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_done", 32'(bus.done), 32'd0);
      chk("mid_rst_result", bus.result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post_rst", MD_REMU, 32'd100, 32'd7, 32'd2, 34, 33);

      // back-to-back issue from the done cycle, with a start poked mid-operation
      issue(MD_DIVU, 32'd100, 32'd7);
      wait_done(-10, cyc, bcyc);
      chk("b2b1_done", 32'(bus.done), 32'd1);
      chk("b2b1_res", bus.result, 32'd14);
      bus.op    = MD_MUL;
      bus.a     = 32'd6;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("b2b2_busy0", 32'(bus.busy), 32'd1);
      chk("b2b2_done0", 32'(bus.done), 32'd0);
      wait_done(6, cyc, bcyc);
      chk("b2b2_done", 32'(bus.done), 32'd1);
      chk("b2b2_res", bus.result, 32'd42);
      chk("b2b2_gap", 32'(cyc), 32'd34);
      @(posedge clk);
      #1;
      chk("b2b2_pulse", 32'(bus.done), 32'd0);
      chk("b2b2_idle", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
